// File: rtl/id_branch_resolve_unit.sv
// Branch resolution in ID: forwards operands, compares, and stalls on pending
// operands up to MAX_WAIT cycles before forcing a not-taken timeout resolution.
//
// state | meaning
// IDLE  | accept a new branch; resolve at once or start waiting on operands
// WAIT  | branch held by stall until operands arrive or the wait budget runs out
module id_branch_resolve_unit #(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3,
  parameter int CNT_W    = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Branch_Valid_ID,
  input  logic [2:0]        Cmp_Op_ID,
  input  logic [DATA_W-1:0] Read_Data_1_ID,
  input  logic [DATA_W-1:0] Read_Data_2_ID,
  input  logic [DATA_W-1:0] Fwd_Data_MEM,
  input  logic [DATA_W-1:0] Write_Data_WB,
  input  logic [1:0]        Fwd_Sel_1_ID,
  input  logic [1:0]        Fwd_Sel_2_ID,
  input  logic              Operand_Pending_ID,
  input  logic              Flush_ID,
  output logic              Stall_ID,
  output logic              Resolve_Valid_ID,
  output logic              Branch_Taken_ID,
  output logic              Timeout_Err,
  output logic [CNT_W-1:0]  Taken_Count
);

  localparam logic       S_IDLE     = 1'b0;
  localparam logic       S_WAIT     = 1'b1;
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic              state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] op1, op2;
  logic              cmp_taken, resolve, timeout_hit, decision;
  logic              op1_neg, op1_zero;

  always_comb begin
    case (Fwd_Sel_1_ID)
      2'b01:   op1 = Fwd_Data_MEM;
      2'b10:   op1 = Write_Data_WB;
      default: op1 = Read_Data_1_ID;
    endcase
    case (Fwd_Sel_2_ID)
      2'b01:   op2 = Fwd_Data_MEM;
      2'b10:   op2 = Write_Data_WB;
      default: op2 = Read_Data_2_ID;
    endcase
  end

  assign op1_neg  = op1[DATA_W-1];
  assign op1_zero = (op1 == '0);

  always_comb begin
    case (Cmp_Op_ID)
      3'b000:  cmp_taken = (op1 == op2);
      3'b001:  cmp_taken = (op1 != op2);
      3'b010:  cmp_taken = op1_neg;
      3'b011:  cmp_taken = !op1_neg;
      3'b100:  cmp_taken = !op1_neg && !op1_zero;
      3'b101:  cmp_taken = op1_neg || op1_zero;
      default: cmp_taken = 1'b0;
    endcase
  end

  always_comb begin
    Stall_ID    = 1'b0;
    resolve     = 1'b0;
    timeout_hit = 1'b0;
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    if (Reset) begin
      state_d    = S_IDLE;
      wait_cnt_d = 4'd0;
    end else if (Flush_ID) begin
      state_d    = S_IDLE;
      wait_cnt_d = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Branch_Valid_ID) begin
            if (Operand_Pending_ID) begin
              Stall_ID   = 1'b1;
              state_d    = S_WAIT;
              wait_cnt_d = 4'd1;
            end else begin
              resolve = 1'b1;
            end
          end
        end
        default: begin
          if (!Operand_Pending_ID) begin
            resolve    = 1'b1;
            state_d    = S_IDLE;
            wait_cnt_d = 4'd0;
          end else if (wait_cnt_q < MAX_WAIT_C) begin
            Stall_ID   = 1'b1;
            wait_cnt_d = wait_cnt_q + 4'd1;
          end else begin
            // Give up on the operand: release the pipe and resolve not-taken.
            timeout_hit = 1'b1;
            resolve     = 1'b1;
            state_d     = S_IDLE;
            wait_cnt_d  = 4'd0;
          end
        end
      endcase
    end
  end

  assign decision = cmp_taken && !timeout_hit;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q          <= S_IDLE;
      wait_cnt_q       <= 4'd0;
      Resolve_Valid_ID <= 1'b0;
      Branch_Taken_ID  <= 1'b0;
      Timeout_Err      <= 1'b0;
      Taken_Count      <= '0;
    end else begin
      state_q          <= state_d;
      wait_cnt_q       <= wait_cnt_d;
      Resolve_Valid_ID <= resolve;
      if (resolve) Branch_Taken_ID <= decision;
      if (resolve && decision) Taken_Count <= Taken_Count + {{(CNT_W-1){1'b0}}, 1'b1};
      if (timeout_hit) Timeout_Err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_branch_resolve_unit.sv
// Directed bench for id_branch_resolve_unit: compare modes, forwarding,
// stall/timeout/flush/reset sequencing and taken-counter wrap.
module tb_id_branch_resolve_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Branch_Valid_ID;
  logic [2:0]  Cmp_Op_ID;
  logic [31:0] Read_Data_1_ID, Read_Data_2_ID, Fwd_Data_MEM, Write_Data_WB;
  logic [1:0]  Fwd_Sel_1_ID, Fwd_Sel_2_ID;
  logic        Operand_Pending_ID, Flush_ID;
  logic        Stall_ID, Resolve_Valid_ID, Branch_Taken_ID, Timeout_Err;
  logic [15:0] Taken_Count;

  int n_chk  = 0;
  int n_pass = 0;

  id_branch_resolve_unit dut (
    .Clk(Clk), .Reset(Reset), .Branch_Valid_ID(Branch_Valid_ID), .Cmp_Op_ID(Cmp_Op_ID),
    .Read_Data_1_ID(Read_Data_1_ID), .Read_Data_2_ID(Read_Data_2_ID),
    .Fwd_Data_MEM(Fwd_Data_MEM), .Write_Data_WB(Write_Data_WB),
    .Fwd_Sel_1_ID(Fwd_Sel_1_ID), .Fwd_Sel_2_ID(Fwd_Sel_2_ID),
    .Operand_Pending_ID(Operand_Pending_ID), .Flush_ID(Flush_ID),
    .Stall_ID(Stall_ID), .Resolve_Valid_ID(Resolve_Valid_ID),
    .Branch_Taken_ID(Branch_Taken_ID), .Timeout_Err(Timeout_Err), .Taken_Count(Taken_Count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] mem, input logic [31:0] wb, input logic [1:0] s1,
                       input logic [1:0] s2, input logic pend, input logic fl);
    @(negedge Clk);
    Branch_Valid_ID = v; Cmp_Op_ID = op; Read_Data_1_ID = r1; Read_Data_2_ID = r2;
    Fwd_Data_MEM = mem; Write_Data_WB = wb; Fwd_Sel_1_ID = s1; Fwd_Sel_2_ID = s2;
    Operand_Pending_ID = pend; Flush_ID = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic rv, input logic bt, input logic te, input logic [15:0] cnt);
    chk({tag, "_rv"}, 32'(Resolve_Valid_ID), 32'(rv));
    chk({tag, "_bt"}, 32'(Branch_Taken_ID), 32'(bt));
    chk({tag, "_te"}, 32'(Timeout_Err), 32'(te));
    chk({tag, "_cnt"}, 32'(Taken_Count), 32'(cnt));
  endtask

  initial begin
    // Reset with a pending branch present: stall must stay low.
    Reset = 1'b1;
    drive(1, 3'b000, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
    chk("rst_stall", 32'(Stall_ID), 0);
    tick(); tick();
    chk_out("rst", 0, 0, 0, 16'd0);
    Reset = 1'b0;

    // EQ on regfile operands
    drive(1, 3'b000, 32'h1234, 32'h1234, 0, 0, 2'b00, 2'b00, 0, 0);
    chk("eq_stall", 32'(Stall_ID), 0);
    tick();
    chk_out("eq", 1, 1, 0, 16'd1);

    // Back-to-back: NE with WB forward on op1 (5 vs 5 -> not taken)
    drive(1, 3'b001, 32'd7, 32'd5, 0, 32'd5, 2'b10, 2'b00, 0, 0);
    tick();
    chk_out("ne_wb", 1, 0, 0, 16'd1);

    drive(1, 3'b010, 32'h8000_0000, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    tick();
    chk_out("ltz", 1, 1, 0, 16'd2);

    drive(1, 3'b100, 32'd0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    tick();
    chk_out("gtz0", 1, 0, 0, 16'd2);

    drive(1, 3'b111, 32'd5, 32'd5, 0, 0, 2'b00, 2'b00, 0, 0);
    tick();
    chk_out("op7", 1, 0, 0, 16'd2);

    // EQ with MEM forward on op2 (9 == 9)
    drive(1, 3'b000, 32'd9, 32'd3, 32'd9, 0, 2'b00, 2'b01, 0, 0);
    tick();
    chk_out("eq_mem", 1, 1, 0, 16'd3);

    // Sel 11 picks the regfile, not the forwarding sources
    drive(1, 3'b000, 32'd4, 32'd4, 32'd1, 32'd2, 2'b11, 2'b11, 0, 0);
    tick();
    chk_out("sel11", 1, 1, 0, 16'd4);

    // LEZ on negative op1, op2 ignored
    drive(1, 3'b101, 32'hFFFF_FFFF, 32'd0, 0, 0, 2'b00, 2'b00, 0, 0);
    tick();
    chk_out("lez", 1, 1, 0, 16'd5);

    // Idle: no pulse, decision held
    drive(0, 3'b000, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0);
    tick();
    chk_out("idle", 0, 1, 0, 16'd5);

    // Pending two cycles then available
    drive(1, 3'b000, 32'd3, 32'd3, 0, 0, 2'b00, 2'b00, 1, 0);
    chk("pw_stall1", 32'(Stall_ID), 1);
    tick();
    chk("pw_rv1", 32'(Resolve_Valid_ID), 0);
    drive(1, 3'b000, 32'd3, 32'd3, 0, 0, 2'b00, 2'b00, 1, 0);
    chk("pw_stall2", 32'(Stall_ID), 1);
    tick();
    chk("pw_rv2", 32'(Resolve_Valid_ID), 0);
    drive(1, 3'b000, 32'd3, 32'd3, 0, 0, 2'b00, 2'b00, 0, 0);
    chk("pw_stall3", 32'(Stall_ID), 0);
    tick();
    chk_out("pw", 1, 1, 0, 16'd6);

    // Pending held: three stall cycles then timeout, not taken
    drive(1, 3'b000, 32'd3, 32'd3, 0, 0, 2'b00, 2'b00, 1, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("to_stall%0d", i), 32'(Stall_ID), 1);
      tick();
      chk($sformatf("to_rv%0d", i), 32'(Resolve_Valid_ID), 0);
      drive(0, 3'b000, 32'd3, 32'd3, 0, 0, 2'b00, 2'b00, 1, 0);
    end
    chk("to_stall_end", 32'(Stall_ID), 0);
    tick();
    chk_out("to", 1, 0, 1, 16'd6);
    drive(0, 3'b000, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    tick();
    chk_out("to_sticky", 0, 0, 1, 16'd6);

    // Flush in WAIT beats a simultaneous resolve and returns to IDLE
    drive(1, 3'b000, 32'd1, 32'd1, 0, 0, 2'b00, 2'b00, 1, 0);
    tick();
    drive(0, 3'b000, 32'd1, 32'd1, 0, 0, 2'b00, 2'b00, 0, 1);
    chk("fl_stall", 32'(Stall_ID), 0);
    tick();
    chk_out("fl", 0, 0, 1, 16'd6);
    drive(0, 3'b000, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
    chk("fl_idle_stall", 32'(Stall_ID), 0);

    // Flush in IDLE with a ready taken branch
    drive(1, 3'b000, 32'd2, 32'd2, 0, 0, 2'b00, 2'b00, 0, 1);
    tick();
    chk_out("fl_idle", 0, 0, 1, 16'd6);

    // Reset mid-WAIT
    drive(1, 3'b000, 32'd2, 32'd2, 0, 0, 2'b00, 2'b00, 1, 0);
    tick();
    Reset = 1'b1;
    drive(0, 3'b000, 32'd2, 32'd2, 0, 0, 2'b00, 2'b00, 1, 0);
    chk("rw_stall", 32'(Stall_ID), 0);
    tick();
    Reset = 1'b0;
    drive(0, 3'b000, 32'd2, 32'd2, 0, 0, 2'b00, 2'b00, 1, 0);
    chk("rw_idle_stall", 32'(Stall_ID), 0);
    chk_out("rw", 0, 0, 0, 16'd0);

    // Counter wrap with back-to-back taken branches
    drive(1, 3'b000, 32'd8, 32'd8, 0, 0, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 65535; i++) tick();
    chk_out("wrap_max", 1, 1, 0, 16'hFFFF);
    tick();
    chk_out("wrap", 1, 1, 0, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
